// File: rtl/axi_ram.sv
// ============================================================================
// Module   : axi_ram
// Purpose  : AXI4-Lite slave RAM backing the rv32 data region. Word-wide,
//            byte-strobed storage with independent read and write channels
//            and one-cycle read latency. Reads capture data before a write
//            committed on the same edge (read-before-write).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BASE - byte address of word 0 (rv32 data base); subtracted from addresses
//   SIZE - capacity in bytes; power of two, >= 4; depth = SIZE/4 words
// Ports:
//   clk                      single clock, rising edge
//   reset                    asynchronous, active-high reset
//   bus_aw{addr,prot,valid}_i / bus_awready_o   write address channel
//   bus_w{data,strb,valid}_i / bus_wready_o     write data channel
//   bus_b{resp,valid}_o      / bus_bready_i     write response channel
//   bus_ar{addr,prot,valid}_i / bus_arready_o   read address channel
//   bus_r{data,resp,valid}_o / bus_rready_i     read data channel
//   (prot inputs are accepted and ignored)
// Build option:
//   AXI_RAM_RANGE_CHECK_EN - when defined, accesses outside
//   [BASE, BASE+SIZE) return SLVERR, writes are dropped and reads return 0.
//   When undefined, the word index wraps modulo depth and all responses OKAY.
// ============================================================================
`default_nettype none

module axi_ram #(
  parameter logic [31:0] BASE = 32'h2000_0000,
  parameter logic [31:0] SIZE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  // write address
  input  logic [31:0] bus_awaddr_i,
  input  logic [2:0]  bus_awprot_i,
  input  logic        bus_awvalid_i,
  output logic        bus_awready_o,
  // write data
  input  logic [31:0] bus_wdata_i,
  input  logic [3:0]  bus_wstrb_i,
  input  logic        bus_wvalid_i,
  output logic        bus_wready_o,
  // write response
  output logic [1:0]  bus_bresp_o,
  output logic        bus_bvalid_o,
  input  logic        bus_bready_i,
  // read address
  input  logic [31:0] bus_araddr_i,
  input  logic [2:0]  bus_arprot_i,
  input  logic        bus_arvalid_i,
  output logic        bus_arready_o,
  // read data
  output logic [31:0] bus_rdata_o,
  output logic [1:0]  bus_rresp_o,
  output logic        bus_rvalid_o,
  input  logic        bus_rready_i
);

  localparam int          ADDR_W    = $clog2(SIZE);
  localparam int          DEPTH     = int'(SIZE >> 2);
  localparam int          IDX_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  logic [31:0] mem_q [DEPTH];

  // write-side state
  w_state_t    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic [1:0]  bresp_q,   bresp_d;

  // read-side state
  r_state_t    r_state_q, r_state_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;

  // --------------------------------------------------------------------------
  // Ready/valid outputs are purely state-derived
  // --------------------------------------------------------------------------
  assign bus_awready_o = (w_state_q == W_IDLE) & ~aw_held_q;
  assign bus_wready_o  = (w_state_q == W_IDLE) & ~w_held_q;
  assign bus_bvalid_o  = (w_state_q == W_RESP);
  assign bus_bresp_o   = bresp_q;
  assign bus_arready_o = (r_state_q == R_IDLE);
  assign bus_rvalid_o  = (r_state_q == R_DATA);
  assign bus_rdata_o   = rdata_q;
  assign bus_rresp_o   = rresp_q;

  // --------------------------------------------------------------------------
  // Write address/data selection: a held beat takes priority over the bus,
  // since the bus side cannot handshake while its holding register is full.
  // --------------------------------------------------------------------------
  logic             w_aw_hs, w_w_hs, w_commit;
  logic [31:0]      w_aw_addr, w_wr_data, w_aw_off;
  logic [3:0]       w_wr_strb;
  logic [IDX_W-1:0] w_aw_idx;
  logic             w_aw_in_range;

  assign w_aw_hs   = bus_awvalid_i & bus_awready_o;
  assign w_w_hs    = bus_wvalid_i  & bus_wready_o;
  assign w_aw_addr = aw_held_q ? awaddr_q : bus_awaddr_i;
  assign w_wr_data = w_held_q  ? wdata_q  : bus_wdata_i;
  assign w_wr_strb = w_held_q  ? wstrb_q  : bus_wstrb_i;
  assign w_commit  = (w_state_q == W_IDLE) & (aw_held_q | w_aw_hs) & (w_held_q | w_w_hs);
  assign w_aw_off  = w_aw_addr - BASE;
  // A single-word RAM always addresses word 0
  assign w_aw_idx  = (DEPTH == 1) ? '0 : IDX_W'(w_aw_off >> 2);

  // Read address decode
  logic             w_ar_hs;
  logic [31:0]      w_ar_off;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_ar_in_range;

  assign w_ar_hs  = bus_arvalid_i & bus_arready_o;
  assign w_ar_off = bus_araddr_i - BASE;
  assign w_ar_idx = (DEPTH == 1) ? '0 : IDX_W'(w_ar_off >> 2);

`ifdef AXI_RAM_RANGE_CHECK_EN
  assign w_aw_in_range = (w_aw_addr    >= BASE) && (w_aw_off < SIZE);
  assign w_ar_in_range = (bus_araddr_i >= BASE) && (w_ar_off < SIZE);
`else
  assign w_aw_in_range = 1'b1;
  assign w_ar_in_range = 1'b1;
`endif

  // Bits intentionally not consumed in every build
  logic w_unused;
  assign w_unused = &{1'b0, bus_awprot_i, bus_arprot_i, w_aw_off, w_ar_off};

  // --------------------------------------------------------------------------
  // Write FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          if (w_aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = bus_awaddr_i;
          end
          if (w_w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = bus_wdata_i;
            wstrb_d  = bus_wstrb_i;
          end
        end
      end
      W_RESP: begin
        if (bus_bready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read FSM: next state. rdata/rresp only change on an AR capture, so they
  // hold steady through backpressure in R_DATA.
  // --------------------------------------------------------------------------
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          rdata_d   = w_ar_in_range ? mem_q[w_ar_idx] : 32'h0;
          rresp_d   = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus_rready_i) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      awaddr_q  <= 32'h0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: not reset. The write is gated by reset so that a commit cannot
  // land while reset is asserted; the read path samples the pre-edge value,
  // which gives read-before-write on a same-word collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit && w_aw_in_range && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) begin
          mem_q[w_aw_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_ram.sv
// ============================================================================
// Module   : tb_axi_ram
// Purpose  : Directed self-checking bench for axi_ram (64-byte instance).
//            Covers reset state, full/partial strobed writes, split AW/W with
//            response backpressure, same-edge read/write collision, access
//            one past the end (AXI_RAM_RANGE_CHECK_EN aware) and reset while
//            transactions are in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_ram;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] SIZE   = 32'd64;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_ram #(.BASE(BASE), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_awaddr_i  (awaddr),
    .bus_awprot_i  (awprot),
    .bus_awvalid_i (awvalid),
    .bus_awready_o (awready),
    .bus_wdata_i   (wdata),
    .bus_wstrb_i   (wstrb),
    .bus_wvalid_i  (wvalid),
    .bus_wready_o  (wready),
    .bus_bresp_o   (bresp),
    .bus_bvalid_o  (bvalid),
    .bus_bready_i  (bready),
    .bus_araddr_i  (araddr),
    .bus_arprot_i  (arprot),
    .bus_arvalid_i (arvalid),
    .bus_arready_o (arready),
    .bus_rdata_o   (rdata),
    .bus_rresp_o   (rresp),
    .bus_rvalid_o  (rvalid),
    .bus_rready_i  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W together, bready high
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid_next", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
    check("wr_bvalid_clear", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rd_rvalid_next", {31'b0, rvalid}, 32'd1);
    check("rd_arready_busy", {31'b0, arready}, 32'd0);
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
    check("rd_rvalid_clear", {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready",  {31'b0, wready},  32'd1);
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_bresp",   {30'b0, bresp},   32'd0);
    check("rst_rresp",   {30'b0, rresp},   32'd0);

    // Full word then byte-strobed updates to BASE+8
    do_write(BASE + 8, 32'hDEAD_BEEF, 4'hF, resp);
    check("w8_bresp", {30'b0, resp}, {30'b0, OKAY});
    do_read(BASE + 8, data, resp);
    check("r8_data", data, 32'hDEAD_BEEF);
    check("r8_rresp", {30'b0, resp}, {30'b0, OKAY});

    do_write(BASE + 8, 32'h0000_00AA, 4'h1, resp);
    do_read(BASE + 8, data, resp);
    check("r8_strb1", data, 32'hDEAD_BEAA);

    do_write(BASE + 8, 32'h1122_3344, 4'hC, resp);
    do_read(BASE + 8, data, resp);
    check("r8_strbC", data, 32'h1122_BEAA);

    // Split AW (cycle 0) / W (cycle 3), bready low until cycle 7
    awaddr = BASE + 12; awvalid = 1'b1; bready = 1'b0;       // cycle 0
    tick();                                                   // cycle 1
    awvalid = 1'b0;
    check("split_c1_awready", {31'b0, awready}, 32'd0);
    check("split_c1_wready",  {31'b0, wready},  32'd1);
    check("split_c1_bvalid",  {31'b0, bvalid},  32'd0);
    tick();                                                   // cycle 2
    check("split_c2_awready", {31'b0, awready}, 32'd0);
    tick();                                                   // cycle 3
    check("split_c3_awready", {31'b0, awready}, 32'd0);
    check("split_c3_bvalid",  {31'b0, bvalid},  32'd0);
    wdata = 32'h55AA_55AA; wstrb = 4'hF; wvalid = 1'b1;
    tick();                                                   // cycle 4
    wvalid = 1'b0;
    check("split_c4_bvalid",  {31'b0, bvalid},  32'd1);
    check("split_c4_bresp",   {30'b0, bresp},   {30'b0, OKAY});
    check("split_c4_awready", {31'b0, awready}, 32'd0);
    check("split_c4_wready",  {31'b0, wready},  32'd0);
    tick();                                                   // cycle 5
    awaddr = BASE + 16; awvalid = 1'b1;
    check("split_c5_awready", {31'b0, awready}, 32'd0);
    check("split_c5_bvalid",  {31'b0, bvalid},  32'd1);
    tick();                                                   // cycle 6
    check("split_c6_awready", {31'b0, awready}, 32'd0);
    check("split_c6_bvalid",  {31'b0, bvalid},  32'd1);
    tick();                                                   // cycle 7
    check("split_c7_bvalid",  {31'b0, bvalid},  32'd1);
    bready = 1'b1;
    tick();                                                   // cycle 8
    bready = 1'b0;
    check("split_c8_bvalid",  {31'b0, bvalid},  32'd0);
    check("split_c8_awready", {31'b0, awready}, 32'd1);
    tick();                                                   // cycle 9
    awvalid = 1'b0;
    check("split_c9_awheld",  {31'b0, awready}, 32'd0);
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();                                                   // cycle 10
    wvalid = 1'b0;
    check("split_c10_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    do_read(BASE + 12, data, resp);
    check("split_r12", data, 32'h55AA_55AA);
    do_read(BASE + 16, data, resp);
    check("split_r16", data, 32'h0BAD_F00D);

    // Same-edge read capture and write commit on BASE+4
    do_write(BASE + 4, 32'h0000_0001, 4'hF, resp);
    awaddr = BASE + 4; araddr = BASE + 4; wdata = 32'h0000_0002; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rbw_rvalid", {31'b0, rvalid}, 32'd1);
    check("rbw_bvalid", {31'b0, bvalid}, 32'd1);
    check("rbw_old",    rdata,           32'h0000_0001);
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(BASE + 4, data, resp);
    check("rbw_new", data, 32'h0000_0002);

    // One past the end
    do_write(BASE, 32'hCAFE_F00D, 4'hF, resp);
    do_write(BASE + SIZE, 32'h1234_5678, 4'hF, resp);
`ifdef AXI_RAM_RANGE_CHECK_EN
    check("oor_bresp", {30'b0, resp}, {30'b0, SLVERR});
    do_read(BASE + SIZE, data, resp);
    check("oor_rresp", {30'b0, resp}, {30'b0, SLVERR});
    check("oor_rdata", data, 32'h0);
    do_read(BASE, data, resp);
    check("oor_word0", data, 32'hCAFE_F00D);
`else
    check("oor_bresp", {30'b0, resp}, {30'b0, OKAY});
    do_read(BASE + SIZE, data, resp);
    check("oor_rresp", {30'b0, resp}, {30'b0, OKAY});
    check("oor_rdata", data, 32'h1234_5678);
    do_read(BASE, data, resp);
    check("oor_word0", data, 32'h1234_5678);
`endif

    // Reset with a held AW and an in-flight read response
    awaddr = BASE + 20; awvalid = 1'b1;
    araddr = BASE + 4;  arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("mid_rvalid_pre",  {31'b0, rvalid},  32'd1);
    check("mid_awready_pre", {31'b0, awready}, 32'd0);
    reset = 1'b1;
    #2;
    check("mid_rvalid_rst",  {31'b0, rvalid},  32'd0);
    check("mid_rdata_rst",   rdata,            32'h0);
    check("mid_awready_rst", {31'b0, awready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    // A lone W must now be held rather than commit against a stale AW
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("mid_no_commit", {31'b0, bvalid}, 32'd0);
    check("mid_wheld",     {31'b0, wready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
